// File: rtl/rfid_axis_framer.sv
// rfid_axis_framer
// Packs the modulated PICC sample stream into fixed-length AXI-Stream frames.
// Samples are optionally decimated and pushed into a small FIFO as
// {last, sign-extended data}. The FIFO head drives the AXIS master port.
// Dropped samples and delivered frames are counted for host-side diagnostics.

module rfid_axis_framer #(
   parameter int SAMPLE_WIDTH           = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int FRAME_LEN              = 256,
   parameter int FIFO_DEPTH             = 16,
   parameter int DECIM_WIDTH            = 8
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic [SAMPLE_WIDTH-1:0]               sample_in,
   input  logic                                  sample_valid_in,
   input  logic                                  enable_in,
   input  logic [DECIM_WIDTH-1:0]                decim_in,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic [15:0]                           drop_count_out,
   output logic [15:0]                           frame_count_out,
   output logic                                  capturing_out
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int IDX_W   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam int DATA_W  = C_M00_AXIS_TDATA_WIDTH;
   localparam int ENTRY_W = DATA_W + 1;
   localparam int STRB_W  = DATA_W / 8;

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [DECIM_WIDTH-1:0]  decim_q, decim_d;
   logic [DECIM_WIDTH-1:0]  decimCnt_q, decimCnt_d;
   logic [IDX_W-1:0]        beatIdx_q, beatIdx_d;
   logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [15:0]             dropCnt_q, dropCnt_d;
   logic [15:0]             frameCnt_q, frameCnt_d;
   logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];

   logic                    fifoEmpty;
   logic                    fifoFull;
   logic                    pop;
   logic                    slotOpen;
   logic                    push;
   logic                    drop;
   logic                    isLastBeat;
   logic [DECIM_WIDTH-1:0]  decimMax;
   logic [DECIM_WIDTH-1:0]  decimNext;
   logic signed [SAMPLE_WIDTH-1:0] sampleSigned;
   logic [DATA_W-1:0]       sampleExt;
   logic [ENTRY_W-1:0]      headEntry;

   // Sign extension of the incoming sample to the stream width.
   assign sampleSigned = sample_in;
   assign sampleExt    = DATA_W'(sampleSigned);

   // FIFO status, handshake and accept/drop decisions.
   assign fifoEmpty  = (count_q == '0);
   assign fifoFull   = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop        = ~fifoEmpty & m00_axis_tready;
   assign slotOpen   = (state_q == CAPTURE) & sample_valid_in & (decimCnt_q == '0);
   assign push       = slotOpen & (~fifoFull | pop);
   assign drop       = slotOpen & fifoFull & ~pop;
   assign isLastBeat = (beatIdx_q == IDX_W'(FRAME_LEN - 1));

   // A decimation of 0 or 1 both mean keep every sample, so the counter never leaves 0.
   assign decimMax  = (decim_q <= DECIM_WIDTH'(1)) ? '0 : (decim_q - 1'b1);
   assign decimNext = (decimCnt_q >= decimMax) ? '0 : (decimCnt_q + 1'b1);

   // Capture FSM, decimation counter and beat index; a dropped sample leaves the
   // counter parked on its accept slot so the next valid sample takes its place.
   always_comb begin
      state_d    = state_q;
      decim_d    = decim_q;
      decimCnt_d = decimCnt_q;
      beatIdx_d  = beatIdx_q;
      case (state_q)
         IDLE: begin
            if (enable_in) begin
               state_d    = CAPTURE;
               decim_d    = decim_in;
               decimCnt_d = '0;
               beatIdx_d  = '0;
            end
         end
         CAPTURE: begin
            if (sample_valid_in) begin
               if (decimCnt_q != '0) begin
                  decimCnt_d = decimNext;
               end else if (push) begin
                  decimCnt_d = decimNext;
                  if (isLastBeat) begin
                     beatIdx_d = '0;
                     if (!enable_in) begin
                        state_d = IDLE;
                     end
                  end else begin
                     beatIdx_d = beatIdx_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FIFO pointers, occupancy and the diagnostic counters.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      dropCnt_d  = dropCnt_q;
      frameCnt_d = frameCnt_q;
      if (push) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (drop && (dropCnt_q != 16'hFFFF)) begin
         dropCnt_d = dropCnt_q + 1'b1;
      end
      if (pop && headEntry[DATA_W]) begin
         frameCnt_d = frameCnt_q + 1'b1;
      end
   end

   // State and counter registers with synchronous reset; reset also flushes the FIFO.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         decim_q    <= '0;
         decimCnt_q <= '0;
         beatIdx_q  <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         dropCnt_q  <= '0;
         frameCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         decim_q    <= decim_d;
         decimCnt_q <= decimCnt_d;
         beatIdx_q  <= beatIdx_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         dropCnt_q  <= dropCnt_d;
         frameCnt_q <= frameCnt_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_q[wrPtr_q] <= {isLastBeat, sampleExt};
      end
   end

   assign headEntry = mem_q[rdPtr_q];

   // Output drive; data and last are forced to 0 while nothing is buffered.
   assign m00_axis_tvalid = ~fifoEmpty;
   assign m00_axis_tdata  = fifoEmpty ? '0 : headEntry[DATA_W-1:0];
   assign m00_axis_tlast  = ~fifoEmpty & headEntry[DATA_W];
   assign m00_axis_tstrb  = {STRB_W{~fifoEmpty}};
   assign drop_count_out  = dropCnt_q;
   assign frame_count_out = frameCnt_q;
   assign capturing_out   = (state_q == CAPTURE);

endmodule

// File: tb/tb_rfid_axis_framer.sv
// Directed testbench for rfid_axis_framer with small frame and FIFO sizes.
// Delivered beats are collected on the falling edge and compared against
// hand-computed expected streams.

module tb_rfid_axis_framer;

   localparam int SW  = 16;
   localparam int DW  = 32;
   localparam int FL  = 4;
   localparam int FD  = 4;
   localparam int DCW = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic [SW-1:0]    sample;
   logic             sampleValid;
   logic             enable;
   logic [DCW-1:0]   decim;
   logic             tready;
   logic             tvalid;
   logic             tlast;
   logic [DW-1:0]    tdata;
   logic [DW/8-1:0]  tstrb;
   logic [15:0]      dropCount;
   logic [15:0]      frameCount;
   logic             capturing;

   int               checkCount = 0;
   int               passCount  = 0;
   int               sent;
   logic [31:0]      dataQ [$];
   logic             lastQ [$];
   logic [31:0]      expQ  [$];

   rfid_axis_framer #(
      .SAMPLE_WIDTH           (SW),
      .C_M00_AXIS_TDATA_WIDTH (DW),
      .FRAME_LEN              (FL),
      .FIFO_DEPTH             (FD),
      .DECIM_WIDTH            (DCW)
   ) dut (
      .clk_in          (clock),
      .rst_in          (reset),
      .sample_in       (sample),
      .sample_valid_in (sampleValid),
      .enable_in       (enable),
      .decim_in        (decim),
      .m00_axis_tready (tready),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tlast  (tlast),
      .m00_axis_tdata  (tdata),
      .m00_axis_tstrb  (tstrb),
      .drop_count_out  (dropCount),
      .frame_count_out (frameCount),
      .capturing_out   (capturing)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Record every completed handshake halfway between rising edges.
   always @(negedge clock) begin
      if (tvalid && tready) begin
         dataQ.push_back(tdata);
         lastQ.push_back(tlast);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then return just after the next rising edge.
   task automatic applyStimulus(input logic en, input logic vld, input logic [SW-1:0] smp);
      enable      = en;
      sampleValid = vld;
      sample      = smp;
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, '0);
   endtask

   // Compare collected beats with expQ; every fourth beat must carry tlast.
   task automatic checkBeats(input string tag);
      checkOutput($sformatf("%s beat count", tag), 32'(dataQ.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++) begin
         if (i < dataQ.size()) begin
            checkOutput($sformatf("%s beat%0d data", tag, i), dataQ[i], expQ[i]);
            checkOutput($sformatf("%s beat%0d last", tag, i), {31'd0, lastQ[i]}, {31'd0, (i % FL) == (FL - 1)});
         end
      end
      dataQ.delete();
      lastQ.delete();
      expQ.delete();
   endtask

   initial begin
      reset       = 1'b1;
      sample      = '0;
      sampleValid = 1'b0;
      enable      = 1'b0;
      decim       = '0;
      tready      = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset tvalid", {31'd0, tvalid}, 32'd0);
      checkOutput("reset tlast", {31'd0, tlast}, 32'd0);
      checkOutput("reset tdata", tdata, 32'd0);
      checkOutput("reset tstrb", {28'd0, tstrb}, 32'd0);
      checkOutput("reset drops", {16'd0, dropCount}, 32'd0);
      checkOutput("reset frames", {16'd0, frameCount}, 32'd0);
      checkOutput("reset capturing", {31'd0, capturing}, 32'd0);
      reset = 1'b0;
      dataQ.delete();
      lastQ.delete();

      // Basic framing: one-cycle enable, samples 1..8, only 1..4 form the frame.
      $display("[TB] basic framing");
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("basic capturing", {31'd0, capturing}, 32'd1);
      applyStimulus(1'b0, 1'b1, 16'd1);
      checkOutput("basic first tvalid", {31'd0, tvalid}, 32'd1);
      checkOutput("basic first tdata", tdata, 32'd1);
      checkOutput("basic first tstrb", {28'd0, tstrb}, 32'h0000000F);
      for (int i = 2; i <= 8; i++) applyStimulus(1'b0, 1'b1, 16'(i));
      idleCycles(6);
      expQ = '{32'd1, 32'd2, 32'd3, 32'd4};
      checkBeats("basic");
      checkOutput("basic idle", {31'd0, capturing}, 32'd0);
      checkOutput("basic frames", {16'd0, frameCount}, 32'd1);

      // Decimation by 3 over samples 0..11.
      $display("[TB] decimation");
      decim = 8'd3;
      applyStimulus(1'b1, 1'b0, '0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 16'(i));
      idleCycles(6);
      expQ = '{32'd0, 32'd3, 32'd6, 32'd9};
      checkBeats("decim");
      checkOutput("decim idle", {31'd0, capturing}, 32'd0);

      // Sign extension of 16-bit samples.
      $display("[TB] sign extension");
      decim = 8'd0;
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 16'hFFFE);
      applyStimulus(1'b0, 1'b1, 16'h7FFF);
      applyStimulus(1'b0, 1'b1, 16'h8000);
      applyStimulus(1'b0, 1'b1, 16'h0005);
      idleCycles(6);
      expQ = '{32'hFFFFFFFE, 32'h00007FFF, 32'hFFFF8000, 32'h00000005};
      checkBeats("sign");
      checkOutput("sign frames", {16'd0, frameCount}, 32'd3);

      // Overflow: six samples into a stalled depth-4 FIFO, two are dropped.
      $display("[TB] overflow");
      tready = 1'b0;
      applyStimulus(1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 16'(10 + i));
         checkOutput($sformatf("ovf hold%0d tdata", i), tdata, 32'd10);
      end
      checkOutput("ovf tvalid", {31'd0, tvalid}, 32'd1);
      checkOutput("ovf tlast", {31'd0, tlast}, 32'd0);
      checkOutput("ovf drops", {16'd0, dropCount}, 32'd2);
      checkOutput("ovf no beats", 32'(dataQ.size()), 32'd0);
      tready = 1'b1;
      idleCycles(8);
      expQ = '{32'd10, 32'd11, 32'd12, 32'd13};
      checkBeats("ovf");
      checkOutput("ovf still capturing", {31'd0, capturing}, 32'd1);

      // Full FIFO with a simultaneous pop: the push is not dropped.
      $display("[TB] full plus pop");
      tready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'(20 + i));
      checkOutput("fullpop drops before", {16'd0, dropCount}, 32'd2);
      tready = 1'b1;
      applyStimulus(1'b1, 1'b1, 16'd30);
      checkOutput("fullpop drops after", {16'd0, dropCount}, 32'd2);
      checkOutput("fullpop tvalid", {31'd0, tvalid}, 32'd1);
      checkOutput("fullpop head", tdata, 32'd21);
      for (int i = 1; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'(30 + i));
      idleCycles(8);
      expQ = '{32'd20, 32'd21, 32'd22, 32'd23, 32'd30, 32'd31, 32'd32, 32'd33};
      checkBeats("fullpop");
      checkOutput("fullpop idle", {31'd0, capturing}, 32'd0);
      checkOutput("fullpop frames", {16'd0, frameCount}, 32'd6);

      // Enable held for three frames with random tready; samples are paced so none drop.
      $display("[TB] enable held");
      sent = 0;
      applyStimulus(1'b1, 1'b0, '0);
      for (int cyc = 0; cyc < 300 && dataQ.size() < 3 * FL; cyc++) begin
         tready = 1'($urandom_range(0, 1));
         if (sent < 3 * FL && (sent - dataQ.size()) < FD) begin
            applyStimulus(sent < 3 * FL - 1, 1'b1, 16'(100 + sent));
            sent++;
         end else begin
            applyStimulus(sent < 3 * FL - 1, 1'b0, '0);
         end
      end
      tready = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'd200);
      applyStimulus(1'b0, 1'b1, 16'd201);
      idleCycles(6);
      for (int i = 0; i < 3 * FL; i++) expQ.push_back(32'(100 + i));
      checkBeats("held");
      checkOutput("held idle", {31'd0, capturing}, 32'd0);
      checkOutput("held frames", {16'd0, frameCount}, 32'd9);

      // Reset mid-frame with two beats buffered.
      $display("[TB] reset mid-frame");
      tready = 1'b0;
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 16'd40);
      applyStimulus(1'b0, 1'b1, 16'd41);
      checkOutput("rst pre tvalid", {31'd0, tvalid}, 32'd1);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'd42);
      reset = 1'b0;
      checkOutput("rst tvalid", {31'd0, tvalid}, 32'd0);
      checkOutput("rst tdata", tdata, 32'd0);
      checkOutput("rst tlast", {31'd0, tlast}, 32'd0);
      checkOutput("rst tstrb", {28'd0, tstrb}, 32'd0);
      checkOutput("rst drops", {16'd0, dropCount}, 32'd0);
      checkOutput("rst frames", {16'd0, frameCount}, 32'd0);
      checkOutput("rst capturing", {31'd0, capturing}, 32'd0);
      tready = 1'b1;
      idleCycles(3);
      applyStimulus(1'b1, 1'b0, '0);
      for (int i = 0; i < FL; i++) applyStimulus(1'b0, 1'b1, 16'(50 + i));
      idleCycles(6);
      expQ = '{32'd50, 32'd51, 32'd52, 32'd53};
      checkBeats("rstfresh");
      checkOutput("rstfresh frames", {16'd0, frameCount}, 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
